monster_fleet: RTL
==================

Name: monster_fleet

Overview:
- Parametrised controller for a row of N_MONS monsters that march as one formation.
- The formation moves right, steps down at the edge, moves left, and repeats.
- Tracks a per-monster alive mask, accepts kill requests from the bullet/collision logic, and detects "landed" and "cleared" end conditions.
- Produces a registered per-pixel monster-hit flag and index for the rgb mux in the top-level display logic.

Parameters:
- N_MONS, 5, number of monsters in the row (2..16)
- X0, 250, reset x centre of monster 0
- Y0, 100, reset y centre of the row
- SPACING, 100, x distance between adjacent monster centres
- HALF_W, 5, monster half-width (box is 2*HALF_W+1 wide)
- HALF_H, 3, monster half-height
- STEP_X, 2, horizontal move per tick
- STEP_Y, 8, vertical drop per edge hit
- X_MIN, 150, leftmost allowed pixel column
- X_MAX, 780, rightmost allowed pixel column
- Y_LIMIT, 520, row landed when bottom edge >= Y_LIMIT
- IW, $clog2(N_MONS), index width

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  reset
- tick  in  1  one-cycle game-update strobe
- hCount  in  10  current pixel column
- vCount  in  10  current pixel row
- kill_valid  in  1  kill request
- kill_idx  in  IW  monster to kill
- alive  out  N_MONS  bit i=1: monster i alive
- fleet_x  out  10  x centre of monster 0
- fleet_y  out  10  y centre of row
- state  out  3  FSM state
- mons_pixel  out  1  registered: pixel lies on a live monster
- mons_idx  out  IW  registered: index of that monster (lowest index wins)
- landed  out  1  row reached Y_LIMIT (sticky)
- cleared  out  1  all monsters dead (sticky)

Behaviour:
- Reset is asynchronous, active-high (rst). All state is clocked on clk rising edge.
- Reset values: alive=all ones, fleet_x=X0, fleet_y=Y0, state=MARCH_R, mons_pixel=0, mons_idx=0, landed=0, cleared=0.
- Geometry:
  - Monster i centre is (fleet_x + i*SPACING, fleet_y).
  - The pixel is on monster i when alive[i], |hCount - cx| <= HALF_W, and |vCount - fleet_y| <= HALF_H, all bounds inclusive.
  - Compare in 11-bit unsigned using the forms (c <= p+H) and (p <= c+H), so edges never underflow.
- Pixel path:
  - mons_pixel and mons_idx are registered every clk, independent of tick: 1-cycle latency from hCount/vCount.
  - When no monster is hit, mons_idx holds 0.
- Edge tests use the full formation (dead monsters included). The right edge is fleet_x + (N_MONS-1)*SPACING + HALF_W.
- FSM, advancing only on tick=1:
  - MARCH_R (0): if right edge + STEP_X > X_MAX, go to DROP_TO_L with no x change; else fleet_x += STEP_X.
  - MARCH_L (1): if fleet_x < X_MIN + HALF_W + STEP_X, go to DROP_TO_R with no x change; else fleet_x -= STEP_X.
  - DROP_TO_L (2) / DROP_TO_R (3): fleet_y += STEP_Y. If new fleet_y + HALF_H >= Y_LIMIT, go to LANDED; else go to MARCH_L / MARCH_R respectively.
  - LANDED (4): terminal; positions frozen; landed=1.
  - CLEARED (5): terminal; positions frozen; cleared=1.
  - Codes 6 and 7 are unused and recover to MARCH_R on the next clk.
- Kill:
  - On kill_valid, clear alive[kill_idx] on the same edge.
  - Ignored if kill_idx >= N_MONS, if the monster is already dead, or in LANDED.
  - A kill and a tick in the same cycle both apply.
- Clear detection: when alive becomes all zeros, state goes to CLEARED on the following clk regardless of tick. CLEARED has priority over a concurrent LANDED transition.
- Reset mid-operation: immediate return to all reset values; no tick is needed.

Optional Feature:
- Macro: FLEET_SPEEDUP_EN.
- Defined: the horizontal step is 2*STEP_X whenever the popcount of alive is <= N_MONS/2. The edge tests use the same effective step.
- Undefined: the step is always STEP_X and no popcount logic is built.

Test Plan:
- Reset, then present hCount=245, vCount=97 -> mons_pixel=1 and mons_idx=0 one clk later. hCount=244 -> mons_pixel=0.
- Defaults, 62 ticks -> fleet_x=374 in MARCH_R. Tick 63 -> DROP_TO_L with fleet_x=374. Tick 64 -> fleet_y=108, MARCH_L. Tick 65 -> fleet_x=372.
- kill_valid with kill_idx=2 -> alive=5'b11011. Pixel (450,100) -> mons_pixel=0. kill_idx=2 again, or kill_idx=7 -> alive unchanged.
- Kill indices 0,1,3,4 with a tick in the same cycle as the final kill -> the tick moves the fleet and clears alive; next clk state=CLEARED, cleared=1; further ticks leave fleet_x/fleet_y unchanged.
- Y_LIMIT=120, run through the drops -> fleet_y 108, 116, then 124 -> LANDED, landed=1; a following kill_valid is ignored.
- Assert rst mid-DROP -> same-cycle fleet_x=250, fleet_y=100, state=0, alive=all ones. With FLEET_SPEEDUP_EN and 3 kills, each tick moves fleet_x by 4.

Source files
------------

// File: rtl/monster_fleet.sv
// monster_fleet: formation controller for one row of N_MONS monsters.
//
// The row marches right, drops a step at the right edge, marches left,
// drops again at the left edge, and repeats. Kill requests clear bits of
// the alive mask. Two terminal conditions exist: the row reaching
// Y_LIMIT (LANDED) and every monster dead (CLEARED). A registered
// per-pixel hit flag and index feed the display colour mux.
//
// Optional build macro: FLEET_SPEEDUP_EN
//   When defined, the horizontal step doubles once half or fewer of the
//   monsters remain alive. When undefined, the step is always STEP_X and
//   no popcount logic is built.
//
// Ports:
//   clk         in   pixel/system clock
//   rst         in   asynchronous active-high reset
//   tick        in   one-cycle game-update strobe
//   hCount      in   current pixel column
//   vCount      in   current pixel row
//   kill_valid  in   kill request
//   kill_idx    in   index of the monster to kill
//   alive       out  bit i set while monster i is alive
//   fleet_x     out  x centre of monster 0
//   fleet_y     out  y centre of the row
//   state       out  FSM state code
//   mons_pixel  out  registered: current pixel lies on a live monster
//   mons_idx    out  registered: lowest index of the monster hit (0 if none)
//   landed      out  row reached Y_LIMIT (sticky)
//   cleared     out  all monsters dead (sticky)
module monster_fleet #(
    parameter int N_MONS  = 5,
    parameter int X0      = 250,
    parameter int Y0      = 100,
    parameter int SPACING = 100,
    parameter int HALF_W  = 5,
    parameter int HALF_H  = 3,
    parameter int STEP_X  = 2,
    parameter int STEP_Y  = 8,
    parameter int X_MIN   = 150,
    parameter int X_MAX   = 780,
    parameter int Y_LIMIT = 520,
    parameter int IW      = $clog2(N_MONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              kill_valid,
    input  logic [IW-1:0]     kill_idx,
    output logic [N_MONS-1:0] alive,
    output logic [9:0]        fleet_x,
    output logic [9:0]        fleet_y,
    output logic [2:0]        state,
    output logic              mons_pixel,
    output logic [IW-1:0]     mons_idx,
    output logic              landed,
    output logic              cleared
);

    typedef enum logic [2:0] {
        MARCH_R   = 3'd0,
        MARCH_L   = 3'd1,
        DROP_TO_L = 3'd2,
        DROP_TO_R = 3'd3,
        LANDED    = 3'd4,
        CLEARED   = 3'd5
    } state_t;

    // Offset from monster 0's centre to the right edge of the last monster.
    localparam int RIGHT_OFF = (N_MONS - 1) * SPACING + HALF_W;

    state_t              state_q, state_d;
    logic [N_MONS-1:0]   alive_q, alive_d;
    logic [9:0]          fleet_x_q, fleet_x_d;
    logic [9:0]          fleet_y_q, fleet_y_d;
    logic                mons_pixel_q, mons_pixel_d;
    logic [IW-1:0]       mons_idx_q, mons_idx_d;

    logic [9:0]          step_x;
    logic                right_hit;
    logic                left_hit;
    logic [9:0]          y_drop;
    logic                land_hit;
    logic                kill_ok;
    logic [N_MONS-1:0]   kill_mask;

`ifdef FLEET_SPEEDUP_EN
    function automatic int unsigned popcount(input logic [N_MONS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N_MONS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    assign step_x = (popcount(alive_q) <= N_MONS / 2) ? 10'(2 * STEP_X) : 10'(STEP_X);
`else
    assign step_x = 10'(STEP_X);
`endif

    // Edge tests cover the whole formation, dead monsters included; widened
    // so the sums cannot wrap.
    assign right_hit = ({2'b00, fleet_x_q} + 12'(RIGHT_OFF) + {2'b00, step_x}) > 12'(X_MAX);
    assign left_hit  = {1'b0, fleet_x_q} < (11'(X_MIN + HALF_W) + {1'b0, step_x});
    assign y_drop    = fleet_y_q + 10'(STEP_Y);
    assign land_hit  = ({1'b0, y_drop} + 11'(HALF_H)) >= 11'(Y_LIMIT);

    assign kill_ok   = kill_valid && (int'(kill_idx) < N_MONS) && (state_q != LANDED);
    assign kill_mask = N_MONS'(1) << kill_idx;

    // Pixel hit test. Both sides of each bound are compared in 11 bits in
    // the c <= p+H / p <= c+H form so nothing underflows near column 0.
    always_comb begin
        logic [10:0] cx;
        logic        y_in;
        mons_pixel_d = 1'b0;
        mons_idx_d   = '0;
        y_in = ({1'b0, fleet_y_q} <= ({1'b0, vCount} + 11'(HALF_H))) &&
               ({1'b0, vCount} <= ({1'b0, fleet_y_q} + 11'(HALF_H)));
        // Walk downwards so the lowest hit index is the one left standing.
        for (int i = N_MONS - 1; i >= 0; i--) begin
            cx = {1'b0, fleet_x_q} + 11'(i * SPACING);
            if (alive_q[i] && y_in &&
                (cx <= ({1'b0, hCount} + 11'(HALF_W))) &&
                ({1'b0, hCount} <= (cx + 11'(HALF_W)))) begin
                mons_pixel_d = 1'b1;
                mons_idx_d   = IW'(i);
            end
        end
    end

    // Formation FSM and alive mask.
    always_comb begin
        state_d   = state_q;
        fleet_x_d = fleet_x_q;
        fleet_y_d = fleet_y_q;
        alive_d   = alive_q;

        if (kill_ok) begin
            alive_d = alive_q & ~kill_mask;
        end

        case (state_q)
            MARCH_R: begin
                if (tick) begin
                    if (right_hit) state_d = DROP_TO_L;
                    else           fleet_x_d = fleet_x_q + step_x;
                end
            end
            MARCH_L: begin
                if (tick) begin
                    if (left_hit) state_d = DROP_TO_R;
                    else          fleet_x_d = fleet_x_q - step_x;
                end
            end
            DROP_TO_L, DROP_TO_R: begin
                if (tick) begin
                    fleet_y_d = y_drop;
                    if (land_hit)                  state_d = LANDED;
                    else if (state_q == DROP_TO_L) state_d = MARCH_L;
                    else                           state_d = MARCH_R;
                end
            end
            LANDED, CLEARED: ;
            default: state_d = MARCH_R;
        endcase

        // An empty row ends the game on the next clock, ahead of any
        // movement or landing decided for that same cycle.
        if ((alive_q == '0) && (state_q != LANDED) && (state_q != CLEARED)) begin
            state_d   = CLEARED;
            fleet_x_d = fleet_x_q;
            fleet_y_d = fleet_y_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MARCH_R;
            alive_q      <= '1;
            fleet_x_q    <= 10'(X0);
            fleet_y_q    <= 10'(Y0);
            mons_pixel_q <= 1'b0;
            mons_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            alive_q      <= alive_d;
            fleet_x_q    <= fleet_x_d;
            fleet_y_q    <= fleet_y_d;
            mons_pixel_q <= mons_pixel_d;
            mons_idx_q   <= mons_idx_d;
        end
    end

    assign alive      = alive_q;
    assign fleet_x    = fleet_x_q;
    assign fleet_y    = fleet_y_q;
    assign state      = state_q;
    assign mons_pixel = mons_pixel_q;
    assign mons_idx   = mons_idx_q;
    assign landed     = (state_q == LANDED);
    assign cleared    = (state_q == CLEARED);

endmodule
